// File: rtl/raid5_stripe_writer.sv
`default_nettype none
// ============================================================================
// Module   : raid5_stripe_writer
// Brief    : Writes one RAID5 stripe across three SD card ports. Each word
//            pair from the SRAM buffers goes out with its XOR parity, one
//            card at a time, and the parity card rotates after each stripe.
// Revision : 1.0 - initial release
// ============================================================================
module raid5_stripe_writer #(
    parameter int BLOCK_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sram1_valid,
    input  logic        sram2_valid,
    input  logic [31:0] sram1_data,
    input  logic [31:0] sram2_data,
    output logic        sram_pop,
    input  logic        sd_ready,
    output logic        sd_valid,
    output logic [1:0]  selectid,
    output logic [1:0]  parity_id,
    output logic [1:0]  sram1sd,
    output logic [1:0]  sram2sd,
    output logic [31:0] sram1_word,
    output logic [31:0] sram2_word,
    output logic [31:0] parity,
    output logic        busy,
    output logic        stripe_done
);

    localparam int                 c_CNT_W     = $clog2(BLOCK_WORDS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(BLOCK_WORDS - 1);
    localparam logic [1:0]         c_LAST_CARD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_word_cnt;
    logic [1:0]         r_selectid;
    logic [1:0]         r_parity_id;
    logic [31:0]        r_sram1_word;
    logic [31:0]        r_sram2_word;
    logic [31:0]        r_parity;
    logic               r_sd_valid;
    logic               r_busy;
    logic               r_stripe_done;

    logic               w_pair_ready;
    logic [1:0]         w_sram1sd;
    logic [1:0]         w_sram2sd;

    // The pop has to coincide with the latching edge, so it cannot be registered.
    assign w_pair_ready = sram1_valid & sram2_valid;
    assign sram_pop     = (r_state == ST_FETCH) & w_pair_ready;

    always_comb begin
        w_sram1sd = 2'd1;
        w_sram2sd = 2'd2;
        case (r_parity_id)
            2'd0: begin
                w_sram1sd = 2'd1;
                w_sram2sd = 2'd2;
            end
            2'd1: begin
                w_sram1sd = 2'd2;
                w_sram2sd = 2'd0;
            end
            2'd2: begin
                w_sram1sd = 2'd0;
                w_sram2sd = 2'd1;
            end
            default: begin
                w_sram1sd = 2'd1;
                w_sram2sd = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_word_cnt    <= '0;
            r_selectid    <= 2'd0;
            r_parity_id   <= 2'd0;
            r_sram1_word  <= 32'd0;
            r_sram2_word  <= 32'd0;
            r_parity      <= 32'd0;
            r_sd_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_stripe_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FETCH;
                        r_word_cnt <= '0;
                        r_selectid <= 2'd0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (w_pair_ready) begin
                        r_sram1_word <= sram1_data;
                        r_sram2_word <= sram2_data;
                        r_parity     <= sram1_data ^ sram2_data;
                        r_selectid   <= 2'd0;
                        r_sd_valid   <= 1'b1;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sd_ready) begin
                        if (r_selectid != c_LAST_CARD) begin
                            r_selectid <= r_selectid + 2'd1;
                        end else if (r_word_cnt == c_LAST_WORD) begin
                            r_sd_valid    <= 1'b0;
                            r_stripe_done <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_word_cnt <= r_word_cnt + c_CNT_W'(1);
                            r_sd_valid <= 1'b0;
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    // Rotating only here keeps the card mapping fixed for a whole stripe.
                    r_parity_id   <= (r_parity_id == 2'd2) ? 2'd0 : r_parity_id + 2'd1;
                    r_stripe_done <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_sd_valid    <= 1'b0;
                    r_busy        <= 1'b0;
                    r_stripe_done <= 1'b0;
                end
            endcase
        end
    end

    assign sd_valid    = r_sd_valid;
    assign selectid    = r_selectid;
    assign parity_id   = r_parity_id;
    assign sram1sd     = w_sram1sd;
    assign sram2sd     = w_sram2sd;
    assign sram1_word  = r_sram1_word;
    assign sram2_word  = r_sram2_word;
    assign parity      = r_parity;
    assign busy        = r_busy;
    assign stripe_done = r_stripe_done;

endmodule
`default_nettype wire

// File: tb/tb_raid5_stripe_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_raid5_stripe_writer
// Brief    : Bench for raid5_stripe_writer with a schedule-based stripe model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raid5_stripe_writer;

    localparam int B = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sram1_valid;
    logic        sram2_valid;
    logic [31:0] sram1_data;
    logic [31:0] sram2_data;
    logic        sram_pop;
    logic        sd_ready;
    logic        sd_valid;
    logic [1:0]  selectid;
    logic [1:0]  parity_id;
    logic [1:0]  sram1sd;
    logic [1:0]  sram2sd;
    logic [31:0] sram1_word;
    logic [31:0] sram2_word;
    logic [31:0] parity;
    logic        busy;
    logic        stripe_done;

    raid5_stripe_writer #(.BLOCK_WORDS(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sram1_valid (sram1_valid),
        .sram2_valid (sram2_valid),
        .sram1_data  (sram1_data),
        .sram2_data  (sram2_data),
        .sram_pop    (sram_pop),
        .sd_ready    (sd_ready),
        .sd_valid    (sd_valid),
        .selectid    (selectid),
        .parity_id   (parity_id),
        .sram1sd     (sram1sd),
        .sram2sd     (sram2sd),
        .sram1_word  (sram1_word),
        .sram2_word  (sram2_word),
        .parity      (parity),
        .busy        (busy),
        .stripe_done (stripe_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          m_pid = 0;
    logic [31:0] cur1  = 32'd0;
    logic [31:0] cur2  = 32'd0;
    logic [31:0] d1 [B];
    logic [31:0] d2 [B];

    function automatic logic rbit();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ids_words(input string tag);
        chk({tag, ".parity_id"}, {30'd0, parity_id}, m_pid);
        chk({tag, ".sram1sd"}, {30'd0, sram1sd}, (m_pid + 1) % 3);
        chk({tag, ".sram2sd"}, {30'd0, sram2sd}, (m_pid + 2) % 3);
        chk({tag, ".sram1_word"}, sram1_word, cur1);
        chk({tag, ".sram2_word"}, sram2_word, cur2);
        chk({tag, ".parity"}, parity, cur1 ^ cur2);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"}, {31'd0, busy}, 0);
        chk({tag, ".sd_valid"}, {31'd0, sd_valid}, 0);
        chk({tag, ".sram_pop"}, {31'd0, sram_pop}, 0);
        chk({tag, ".stripe_done"}, {31'd0, stripe_done}, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start       = 1'b0;
            rst         = 1'b0;
            sram1_valid = rbit();
            sram2_valid = rbit();
            sram1_data  = $urandom;
            sram2_data  = $urandom;
            sd_ready    = rbit();
            #1;
            chk_quiet("idle");
            chk_ids_words("idle");
            @(posedge clk); #1;
        end
    endtask

    task automatic random_data();
        for (int i = 0; i < B; i++) begin
            d1[i] = $urandom;
            d2[i] = $urandom;
        end
    endtask

    // Each word w owns a window starting at f[w]: (stall+1) FETCH cycles,
    // then three accepted SEND cycles plus any backpressure; DONE lands at f[B].
    task automatic run_stripe(input bit hold_start, input int st_word, input int st_len,
                              input int bp_word, input int bp_sel, input int bp_len,
                              input int rst_cycle, input int exp_done);
        int f [B+1];
        int w, stall, off, k, sel, done_obs, pops;
        bit fetch, stalled, send_ph, done_ph, bp_win;
        logic [31:0] obs_emit, exp_emit;
        f[0] = 1;
        for (int i = 0; i < B; i++)
            f[i+1] = f[i] + ((i == st_word) ? st_len : 0) + 4 + ((i == bp_word) ? bp_len : 0);
        done_obs = -1;
        pops     = 0;

        start       = 1'b1;
        rst         = 1'b0;
        sram1_valid = rbit();
        sram2_valid = rbit();
        sram1_data  = $urandom;
        sram2_data  = $urandom;
        sd_ready    = rbit();
        #1;
        chk_quiet("c0");
        chk_ids_words("c0");
        @(posedge clk); #1;

        for (int cyc = 1; cyc <= f[B]; cyc++) begin
            w = 0;
            for (int i = 0; i < B; i++)
                if (cyc >= f[i]) w = i;
            done_ph = (cyc == f[B]);
            stall   = (w == st_word) ? st_len : 0;
            off     = cyc - f[w];
            fetch   = !done_ph && (off <= stall);
            stalled = fetch && (off < stall);
            send_ph = !done_ph && !fetch;
            k       = off - stall - 1;
            bp_win  = send_ph && (w == bp_word) && (k >= bp_sel) && (k < bp_sel + bp_len);
            sel     = k;
            if (send_ph && (w == bp_word) && (k >= bp_sel))
                sel = (k < bp_sel + bp_len) ? bp_sel : k - bp_len;

            start       = hold_start ? 1'b1 : rbit();
            rst         = (cyc == rst_cycle);
            sram1_valid = fetch ? (stalled ? rbit() : 1'b1) : rbit();
            sram2_valid = fetch ? !stalled : rbit();
            sram1_data  = fetch ? d1[w] : $urandom;
            sram2_data  = (fetch && !stalled) ? d2[w] : $urandom;
            sd_ready    = send_ph ? !bp_win : rbit();
            #1;
            chk("busy", {31'd0, busy}, 1);
            chk("sd_valid", {31'd0, sd_valid}, send_ph);
            chk("sram_pop", {31'd0, sram_pop}, fetch && !stalled);
            chk("stripe_done", {31'd0, stripe_done}, done_ph);
            chk_ids_words("stripe");
            if (send_ph) begin
                chk("selectid", {30'd0, selectid}, sel);
                obs_emit = (selectid == sram1sd) ? sram1_word :
                           (selectid == sram2sd) ? sram2_word : parity;
                exp_emit = (sel == m_pid) ? (cur1 ^ cur2) :
                           (sel == (m_pid + 1) % 3) ? cur1 : cur2;
                chk("card_word", obs_emit, exp_emit);
            end
            if (sram_pop) pops++;
            if (stripe_done && done_obs < 0) done_obs = cyc;
            @(posedge clk); #1;
            if (rst) begin
                rst   = 1'b0;
                m_pid = 0;
                cur1  = 32'd0;
                cur2  = 32'd0;
                chk("rst.busy", {31'd0, busy}, 0);
                chk("rst.stripe_done", {31'd0, stripe_done}, 0);
                chk("rst.sd_valid", {31'd0, sd_valid}, 0);
                chk("rst.selectid", {30'd0, selectid}, 0);
                chk_ids_words("rst");
                return;
            end
            if (fetch && !stalled) begin
                cur1 = d1[w];
                cur2 = d2[w];
            end
            if (done_ph) m_pid = (m_pid + 1) % 3;
        end
        chk("done_cycle", done_obs, exp_done);
        chk("pop_count", pops, B);
    endtask

    initial begin
        int sw, sl, bw, bs, bl;
        rst         = 1'b1;
        start       = 1'b0;
        sram1_valid = 1'b0;
        sram2_valid = 1'b0;
        sram1_data  = 32'd0;
        sram2_data  = 32'd0;
        sd_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset.selectid", {30'd0, selectid}, 0);
        chk("reset.sram1sd", {30'd0, sram1sd}, 1);
        chk("reset.sram2sd", {30'd0, sram2sd}, 2);
        chk_ids_words("reset");
        @(posedge clk); #1;
        idle_cycles(2);

        // Basic stripe with the directed word pairs
        d1[0] = 32'hA5A5A5A5; d2[0] = 32'h0F0F0F0F;
        d1[1] = 32'd1;        d2[1] = 32'd2;
        d1[2] = 32'hFFFFFFFF; d2[2] = 32'd0;
        d1[3] = 32'd3;        d2[3] = 32'd3;
        run_stripe(1'b0, -1, 0, -1, 0, 0, -1, 17);
        chk("basic.parity_id", {30'd0, parity_id}, 1);

        // Rotation: two more stripes back to back
        random_data();
        run_stripe(1'b0, -1, 0, -1, 0, 0, -1, 17);
        random_data();
        run_stripe(1'b0, -1, 0, -1, 0, 0, -1, 17);
        chk("rotation.parity_id", {30'd0, parity_id}, 0);
        idle_cycles(2);

        // Backpressure: 3 ready-low cycles at selectid=1 of word 2
        random_data();
        run_stripe(1'b0, -1, 0, 2, 1, 3, -1, 20);

        // Starvation: sram2 empty for 5 FETCH cycles of word 1
        random_data();
        run_stripe(1'b0, 1, 5, -1, 0, 0, -1, 22);
        idle_cycles(1);

        // Random stalls and backpressure
        for (int r = 0; r < 2; r++) begin
            random_data();
            sw = $urandom_range(B - 1, 0);
            sl = $urandom_range(4, 0);
            bw = $urandom_range(B - 1, 0);
            bs = $urandom_range(2, 0);
            bl = $urandom_range(3, 0);
            run_stripe(1'b0, sw, sl, bw, bs, bl, -1, 17 + sl + bl);
        end

        // Reset during word 1 of the second stripe
        random_data();
        run_stripe(1'b0, -1, 0, -1, 0, 0, -1, 17);
        random_data();
        run_stripe(1'b0, -1, 0, -1, 0, 0, 6, 0);
        idle_cycles(3);

        // start held through DONE launches exactly one more stripe
        random_data();
        run_stripe(1'b1, -1, 0, -1, 0, 0, -1, 17);
        random_data();
        run_stripe(1'b0, -1, 0, -1, 0, 0, -1, 17);
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/raid5_stripe_writer.md
# raid5_stripe_writer

Sequences one RAID5 stripe write across the three SD card ports. It pulls word pairs from the two SRAM data buffers and computes the XOR parity word. It then drives the SD data-in select mux (selectid, sram1sd, sram2sd, plus the three data words) one card at a time under a valid/ready handshake. The parity card rotates across disks 0→1→2→0 on each completed stripe.

## Interface
Parameters:
- BLOCK_WORDS, 128, 32-bit words per card per stripe (512-byte sector); legal range 1 to 65535.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  request one stripe write; sampled only in IDLE.
- sram1_valid  in  1  word available at sram1_data.
- sram2_valid  in  1  word available at sram2_data.
- sram1_data  in  32  next data word for the first data card.
- sram2_data  in  32  next data word for the second data card.
- sram_pop  out  1  one-cycle pulse that consumes the current word from both SRAM buffers.
- sd_ready  in  1  SD write path accepts the presented word.
- sd_valid  out  1  word presented to the SD write path.
- selectid  out  2  card currently being written (0..2).
- parity_id  out  2  card holding parity for the current stripe.
- sram1sd  out  2  card receiving sram1 words = (parity_id+1) mod 3.
- sram2sd  out  2  card receiving sram2 words = (parity_id+2) mod 3.
- sram1_word  out  32  latched sram1 word.
- sram2_word  out  32  latched sram2 word.
- parity  out  32  latched sram1_word XOR sram2_word.
- busy  out  1  high in every state except IDLE.
- stripe_done  out  1  one-cycle pulse when the stripe completes.

## Operation
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 → FETCH; word_cnt and selectid are cleared.
  - start=0 → remain in IDLE.
- FETCH:
  - If sram1_valid and sram2_valid are both high: pulse sram_pop, latch sram1_word/sram2_word/parity, set selectid=0, go to SEND.
  - Otherwise wait. Do not pop and do not change the latched words.
- SEND:
  - sd_valid=1.
  - If sd_ready=1 and selectid<2: selectid increments.
  - If sd_ready=1 and selectid==2 and word_cnt==BLOCK_WORDS-1: go to DONE.
  - If sd_ready=1 and selectid==2 otherwise: word_cnt increments and the FSM returns to FETCH.
  - sd_ready=0 holds every output.
- DONE:
  - stripe_done=1 for exactly one cycle.
  - parity_id advances (2 wraps to 0).
  - Next state is IDLE.
- word_cnt width is $clog2(BLOCK_WORDS+1). It never exceeds BLOCK_WORDS-1.
- start outside IDLE is ignored; there is no queuing.
- sram1sd and sram2sd are combinational from parity_id. The three ids are always distinct.
- The downstream mux therefore emits sram1_word, sram2_word and parity in card order 0,1,2. Which card gets which word depends on parity_id.

## Timing
- Reset values:
  - State IDLE.
  - parity_id=0, so sram1sd=1 and sram2sd=2.
  - selectid=0, word_cnt=0.
  - sram1_word, sram2_word and parity are all 0.
  - sd_valid, sram_pop, busy and stripe_done are all 0.
- Reset mid-stripe: the FSM returns to IDLE on the next edge and parity_id returns to 0. No further pop or sd_valid is issued. A partially written stripe is abandoned.
- Latency:
  - Cycle 0: start=1 is sampled in IDLE.
  - Cycle 1: FETCH.
  - Cycle 2: with both valids high in cycle 1, sd_valid=1 and selectid=0.
  - Per word, best case: 1 FETCH cycle plus 3 SEND cycles.
  - With continuous valid/ready, stripe_done asserts in cycle 4·BLOCK_WORDS+1.
- sram_pop asserts only in a FETCH cycle where both valids are high, and only once per word.
- sd_valid is never asserted in FETCH, IDLE or DONE.
- sd_ready is ignored when sd_valid=0.
- parity_id changes only on the DONE→IDLE edge, so sram1sd and sram2sd are stable for the whole stripe.
- start asserted in the DONE cycle is ignored. It must be held or reasserted in IDLE.

## Test plan
All scenarios use BLOCK_WORDS=4.
- Reset then idle check: all outputs at their reset values, sram1sd=1, sram2sd=2.
- Basic stripe:
  - Stimulus: start pulse; valids and sd_ready tied high; word pairs (0xA5A5A5A5, 0x0F0F0F0F), (1,2), (0xFFFFFFFF,0), (3,3).
  - Parity sequence: 0xAAAAAAAA, 3, 0xFFFFFFFF, 0.
  - selectid sequence 0,1,2 per word; 4 sram_pop pulses; stripe_done at cycle 17; parity_id 0→1.
- Rotation:
  - Three back-to-back stripes: during the stripes, (parity_id, sram1sd, sram2sd) = (0,1,2), (1,2,0), (2,0,1).
  - After the third stripe, parity_id returns to 0.
- Backpressure: sd_ready low for 3 cycles at selectid=1 of word 2. selectid, sd_valid=1 and all data words hold; no extra pop; stripe_done is delayed by exactly 3 cycles.
- Starvation: sram2_valid low for 5 cycles in FETCH. No sram_pop and no sd_valid during the stall; the latched words are unchanged until both valids are high.
- Reset and start edge cases:
  - rst asserted during word 1 of stripe 2: the FSM is in IDLE the next cycle with parity_id=0 and no stripe_done.
  - start held high through DONE: exactly one new stripe begins, from IDLE.
